md_unit_param: RTL
==================

MD_UNIT_PARAM -- requirements
Module: md_unit_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu (and madd family), legal range >=1.
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu, legal range >=1.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  qualifies MDop; low = nop.
REQ-007 SHALL have port flush  input  1  aborts in-flight operation.
REQ-008 SHALL have port MDop  input  4  op: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu, 13-15 nop.
REQ-009 SHALL have ports A, B  input  WIDTH  operands (A = rs/dividend, B = rt/divisor).
REQ-010 SHALL have ports HI, LO  output  WIDTH  architectural registers.
REQ-011 SHALL have port out  output  WIDTH  mfhi/mflo read data.
REQ-012 SHALL have port busy  output  1  high while a multi-cycle op is in flight.

Function
REQ-013 SHALL implement two states IDLE and BUSY plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 SHALL accept a compute op (1-4, 9-12) on a rising edge with en=1, state IDLE, flush=0; A, B, op latched at that edge; state->BUSY, counter loaded.
REQ-015 SHALL hold busy=1 for exactly MULT_CYCLES (mult family) or DIV_CYCLES (div family) consecutive cycles following acceptance.
REQ-016 SHALL write HI/LO on the edge ending the last busy cycle; busy=0 and new HI/LO visible in the same following cycle.
REQ-017 SHALL ignore all ops with en=1 while BUSY (no write, no re-accept); the stall unit holds the instruction.
REQ-018 SHALL write A to HI (mthi) or LO (mtlo) on the edge when en=1, state IDLE, flush=0; one-cycle, busy stays 0.
REQ-019 SHALL drive out combinationally: HI when en=1 and MDop=5, LO when en=1 and MDop=6, else 0.
REQ-020 mult: {HI,LO} = signed A*B (2*WIDTH bits); multu: unsigned product.
REQ-021 madd/maddu: {HI,LO} += product (signed/unsigned), msub/msubu: {HI,LO} -= product; HI/LO read at completion edge, modulo 2^(2*WIDTH).
REQ-022 div: LO = quotient truncated toward zero, HI = remainder with dividend's sign; divu unsigned.
REQ-023 SHALL, on divisor 0: LO = all ones, HI = A.
REQ-024 SHALL, on signed div of most-negative / -1: LO = most-negative, HI = 0.
REQ-025 SHALL, on flush=1 while BUSY: return to IDLE next edge, busy=0, HI/LO unchanged; flush in IDLE blocks acceptance that cycle.
REQ-026 SHALL allow a new op to be accepted on the first cycle busy is 0 after completion (back-to-back with zero gap).

Reset
REQ-027 SHALL on reset=0, asynchronously: HI=0, LO=0, busy=0, state IDLE, counter 0, latched operands 0.
REQ-028 SHALL abort any in-flight op on reset with no HI/LO write; first accept possible on first edge after reset deasserts.

Configuration
REQ-029 SHALL use macro MDU_MADD_EN: defined -> opcodes 9-12 behave per REQ-021; undefined -> 9-12 are nop, no accumulate adder synthesised.

Verification
REQ-030 Reset: assert reset=0 mid-mult -> HI=LO=0, busy=0 immediately, no later write.
REQ-031 mult A=0xFFFFFFFF B=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-032 div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; div A=5 B=0 -> LO=0xFFFFFFFF HI=0x00000005; div 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-033 mthi A=0x1234 while BUSY -> ignored; after completion mfhi -> out=mult result HI; flush at busy cycle 3 -> HI/LO keep prior values, busy=0 next cycle.
REQ-034 With MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, madd A=1 B=1 -> HI=1 LO=0; without macro same stimulus -> HI/LO unchanged, busy never asserts.

Source files
------------

// File: rtl/md_unit_param_if.sv
// Operand/result bundle between the pipeline and the multiply/divide unit.
// The master drives op and operands; the slave returns HI/LO, read data and busy.
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             flush;
  logic [3:0]       MDop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (output en, flush, MDop, A, B, input HI, LO, out, busy);
  modport slave  (input en, flush, MDop, A, B, output HI, LO, out, busy);
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (opcodes 9-12); otherwise they are nops.
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic              clk,
  input logic              reset,
  md_unit_param_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, a_q, b_q;
  logic [3:0]         op_q;
  logic               start_mult, start_div, idle_go, load, done;

  always_comb begin
    start_mult = 1'b0;
    start_div  = 1'b0;
    case (bus.MDop)
      OP_MULT, OP_MULTU: start_mult = 1'b1;
      OP_DIV,  OP_DIVU:  start_div  = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_mult = 1'b1;
`endif
      default: ;
    endcase
  end

  assign idle_go = (state == IDLE) && bus.en && !bus.flush;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (idle_go && (start_mult || start_div)) begin
        next_state = BUSY;
        load       = 1'b1;
      end
      BUSY: if (bus.flush) begin
        next_state = IDLE;
      end else if (cnt == CW'(1)) begin
        next_state = IDLE;
        done       = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values, regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Result datapath works from the operands latched at acceptance.
  logic               op_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, result;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, q_mag, r_mag, quot, rem;

  always_comb begin
    op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
    op_signed = op_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    a_ext   = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;

    // Sign-magnitude division: most-negative / -1 falls out as most-negative, remainder 0.
    a_neg = op_signed && a_q[WIDTH-1];
    b_neg = op_signed && b_q[WIDTH-1];
    a_abs = a_neg ? -a_q : a_q;
    b_abs = b_neg ? -b_q : b_q;
    q_mag = (b_q == '0) ? '0 : a_abs / b_abs;
    r_mag = (b_q == '0) ? '0 : a_abs % b_abs;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    result = {hi, lo};
    case (op_q)
      OP_MULT, OP_MULTU: result = product;
      OP_DIV,  OP_DIVU:  result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: result = {hi, lo} + product;
      OP_MSUB, OP_MSUBU: result = {hi, lo} - product;
`endif
      default: ;
    endcase
  end

  // NOTE: operand latches are reset too, so an aborted op can never leak stale data into a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (load) begin
        cnt  <= start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= bus.MDop;
      end else if (state == BUSY) begin
        cnt <= bus.flush ? '0 : cnt - CW'(1);
      end

      if (done) begin
        {hi, lo} <= result;
      end else if (idle_go && bus.MDop == OP_MTHI) begin
        hi <= bus.A;
      end else if (idle_go && bus.MDop == OP_MTLO) begin
        lo <= bus.A;
      end
    end
  end

  always_comb begin
    bus.out = '0;
    if (bus.en && bus.MDop == OP_MFHI) bus.out = hi;
    else if (bus.en && bus.MDop == OP_MFLO) bus.out = lo;
  end

  assign bus.HI   = hi;
  assign bus.LO   = lo;
  assign bus.busy = (state == BUSY);

endmodule
